// File: rtl/rip_dmem_ctrl_if.sv
// Port-1 bus bundle for rip_dmem_ctrl: CPU request/response handshake plus the BRAM port-1 pins.
// The controller takes the slave side; the CPU/BRAM environment takes the master side.
interface rip_dmem_ctrl_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_err;
  logic [31:0]           rsp_rdata;
  logic                  mem_enable;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_we;
  logic [31:0]           mem_din;
  logic [31:0]           mem_dout;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
           mem_enable, mem_addr, mem_we, mem_din
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dout,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
           mem_enable, mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/rip_dmem_ctrl.sv
// RV32 load/store sequencer for BRAM port 1: byte enables, store-data shifting, load extension,
// and splitting of word-crossing accesses into two BRAM cycles.
module rip_dmem_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter bit SPLIT_EN   = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  rip_dmem_ctrl_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_ACC1, S_ACC2, S_RESP, S_ERR} state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           lo_q, lo_d;
  logic                  split_q, split_d;

  logic                  mem_enable_q, mem_enable_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_we_q, mem_we_d;
  logic [31:0]           mem_din_q, mem_din_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  req_ready;
  logic                  accept;
  logic [3:0]            size_mask;
  logic [7:0]            bmask8;
  logic [63:0]           wd64;
  logic                  illegal, out_of_range, misaligned;
  logic [63:0]           r64;
  logic [31:0]           x;
  logic [31:0]           rdata;

  // Gated by rst so the requester never sees ready while reset is held.
  assign req_ready = (state_q == S_IDLE) && !rst;
  assign accept    = bus.req_valid && req_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no branch leaves it unassigned (no latches).
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    split_d = split_q;

    if (accept) begin
      we_d    = bus.req_we;
      f3_d    = bus.req_funct3;
      addr_d  = bus.req_addr[ADDR_WIDTH+1:0];
      wdata_d = bus.req_wdata;
    end

    unique case (f3_d[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    bmask8 = {4'b0000, size_mask} << addr_d[1:0];
    wd64   = {32'b0, wdata_d} << {addr_d[1:0], 3'b000};
    if (accept) split_d = |bmask8[7:4];

    illegal      = we_d ? (f3_d >= 3'b011) : ((f3_d[1:0] == 2'b11) || (f3_d == 3'b110));
    out_of_range = |bus.req_addr[31:ADDR_WIDTH+2];
    misaligned   = !SPLIT_EN && (|bmask8[7:4]);

    unique case (state_q)
      S_IDLE: if (accept) state_d = (illegal || out_of_range || misaligned) ? S_ERR : S_ACC1;
      S_ACC1: state_d = split_q ? S_ACC2 : S_RESP;
      S_ACC2: begin
        state_d = S_RESP;
        lo_d    = bus.mem_dout;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight out of flops.
    mem_enable_d = 1'b0;
    mem_addr_d   = '0;
    mem_we_d     = 4'b0000;
    mem_din_d    = 32'b0;
    rsp_valid_d  = (state_d == S_RESP) || (state_d == S_ERR);
    rsp_err_d    = (state_d == S_ERR);
    if (state_d == S_ACC1) begin
      mem_enable_d = 1'b1;
      mem_addr_d   = addr_d[ADDR_WIDTH+1:2];
      if (we_d) begin
        mem_we_d  = bmask8[3:0];
        mem_din_d = wd64[31:0];
      end
    end else if (state_d == S_ACC2) begin
      mem_enable_d = 1'b1;
      mem_addr_d   = addr_d[ADDR_WIDTH+1:2] + 1'b1;
      if (we_d) begin
        mem_we_d  = bmask8[7:4];
        mem_din_d = wd64[63:32];
      end
    end
  end

  // Load result depends on BRAM data arriving in RESP, so it is decoded rather than registered.
  always_comb begin
    r64   = split_q ? {bus.mem_dout, lo_q} : {32'b0, bus.mem_dout};
    x     = 32'(r64 >> {addr_q[1:0], 3'b000});
    rdata = 32'b0;
    if (state_q == S_RESP && !we_q) begin
      unique case (f3_q)
        3'b000:  rdata = {{24{x[7]}}, x[7:0]};
        3'b001:  rdata = {{16{x[15]}}, x[15:0]};
        3'b100:  rdata = {24'b0, x[7:0]};
        3'b101:  rdata = {16'b0, x[15:0]};
        default: rdata = x;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: capture registers are reset with the control state so post-reset contents are deterministic.
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'b0;
      lo_q         <= 32'b0;
      split_q      <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 4'b0000;
      mem_din_q    <= 32'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop updates from the same pre-edge values.
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lo_q         <= lo_d;
      split_q      <= split_d;
      mem_enable_q <= mem_enable_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_din_q    <= mem_din_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_rdata  = rdata;
  assign bus.mem_enable = mem_enable_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_din    = mem_din_q;

endmodule

// File: tb/tb_rip_dmem_ctrl.sv
// Directed bench for rip_dmem_ctrl: a split-enabled instance backed by a byte-write BRAM model,
// plus a SPLIT_EN=0 instance used only for the misaligned-error path.
module tb_rip_dmem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rip_dmem_ctrl_if #(.ADDR_WIDTH(10)) bus  ();
  rip_dmem_ctrl_if #(.ADDR_WIDTH(10)) bus0 ();

  rip_dmem_ctrl #(.ADDR_WIDTH(10), .SPLIT_EN(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  rip_dmem_ctrl #(.ADDR_WIDTH(10), .SPLIT_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  // Byte-write BRAM, one-cycle read latency, read-old-data.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (bus.mem_enable) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_din[8*b +: 8];
      bus.mem_dout <= mem[bus.mem_addr];
    end
  end
  assign bus0.mem_dout = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rsp_valid"},  {31'b0, bus.rsp_valid},  32'd0);
    check({tag, "_rsp_err"},    {31'b0, bus.rsp_err},    32'd0);
    check({tag, "_rsp_rdata"},  bus.rsp_rdata,           32'd0);
    check({tag, "_mem_enable"}, {31'b0, bus.mem_enable}, 32'd0);
    check({tag, "_mem_addr"},   {22'b0, bus.mem_addr},   32'd0);
    check({tag, "_mem_we"},     {28'b0, bus.mem_we},     32'd0);
    check({tag, "_mem_din"},    bus.mem_din,             32'd0);
  endtask

  // Waits (bounded) for ready, presents one request for one edge, then scrambles the inputs.
  // Returns #1 after the accepting edge, i.e. inside cycle T1.
  task automatic start(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int w = 0;
    while (!bus.req_ready && w < 10) begin
      cyc();
      w++;
    end
    check("ready_wait", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    cyc();
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_funct3 = 3'b111;
    bus.req_addr   = 32'hFFFF_FFFF;
    bus.req_wdata  = 32'hA5A5_A5A5;
  endtask

  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
    int   lat    = 1;
    logic saw_en = 1'b0;
    start(we, f3, addr, wdata);
    while (!bus.rsp_valid && lat < 6) begin
      saw_en |= bus.mem_enable;
      cyc();
      lat++;
    end
    saw_en |= bus.mem_enable;
    check({tag, "_lat"},   32'(lat),               32'(exp_lat));
    check({tag, "_err"},   {31'b0, bus.rsp_err},   {31'b0, exp_err});
    check({tag, "_rdata"}, bus.rsp_rdata,          exp_rd);
    if (exp_err) check({tag, "_no_mem"}, {31'b0, saw_en}, 32'd0);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int   n_acc, n_rsp;
    logic saw;
    bus.req_valid   = 1'b0;
    bus.req_we      = 1'b0;
    bus.req_funct3  = 3'b000;
    bus.req_addr    = 32'h0;
    bus.req_wdata   = 32'h0;
    bus0.req_valid  = 1'b0;
    bus0.req_we     = 1'b0;
    bus0.req_funct3 = 3'b000;
    bus0.req_addr   = 32'h0;
    bus0.req_wdata  = 32'h0;

    // Reset: everything low, including ready; ready rises as soon as rst drops.
    repeat (3) cyc();
    check("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    check_quiet("rst");
    rst = 1'b0;
    #1;
    check("rst_release_ready", {31'b0, bus.req_ready}, 32'd1);
    cyc();

    // 1: aligned SW / LW.
    start(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    check("sw_en",   {31'b0, bus.mem_enable}, 32'd1);
    check("sw_addr", {22'b0, bus.mem_addr},   32'd4);
    check("sw_we",   {28'b0, bus.mem_we},     32'hF);
    check("sw_din",  bus.mem_din,             32'hDEAD_BEEF);
    check("sw_t1_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    cyc();
    check("sw_t2_rsp", {31'b0, bus.rsp_valid}, 32'd1);
    check("sw_t2_err", {31'b0, bus.rsp_err},   32'd0);
    check("sw_t2_en",  {31'b0, bus.mem_enable}, 32'd0);
    check("sw_t2_rd",  bus.rsp_rdata,           32'd0);
    cyc();
    xact("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'hDEAD_BEEF);

    // 2: byte store to the top lane, signed and unsigned byte loads.
    start(1'b1, 3'b000, 32'h13, 32'h80);
    check("sb_addr", {22'b0, bus.mem_addr}, 32'd4);
    check("sb_we",   {28'b0, bus.mem_we},   32'h8);
    check("sb_din",  bus.mem_din,           32'h8000_0000);
    cyc();
    check("sb_rsp", {31'b0, bus.rsp_valid}, 32'd1);
    cyc();
    xact("lb13",  1'b0, 3'b000, 32'h13, 32'h0, 2, 1'b0, 32'hFFFF_FF80);
    xact("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 2, 1'b0, 32'h0000_0080);
    xact("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'h80AD_BEEF);

    // 3: word store crossing into the next word, then split/unsplit loads of it.
    start(1'b1, 3'b010, 32'h21, 32'h1122_3344);
    check("ssw_a1_addr", {22'b0, bus.mem_addr}, 32'd8);
    check("ssw_a1_we",   {28'b0, bus.mem_we},   32'hE);
    check("ssw_a1_din",  bus.mem_din,           32'h2233_4400);
    cyc();
    check("ssw_a2_en",   {31'b0, bus.mem_enable}, 32'd1);
    check("ssw_a2_addr", {22'b0, bus.mem_addr},   32'd9);
    check("ssw_a2_we",   {28'b0, bus.mem_we},     32'h1);
    check("ssw_a2_din",  bus.mem_din,             32'h0000_0011);
    check("ssw_a2_rsp",  {31'b0, bus.rsp_valid},  32'd0);
    cyc();
    check("ssw_t3_rsp", {31'b0, bus.rsp_valid}, 32'd1);
    check("ssw_t3_err", {31'b0, bus.rsp_err},   32'd0);
    cyc();
    xact("slw21",  1'b0, 3'b010, 32'h21, 32'h0, 3, 1'b0, 32'h1122_3344);
    xact("lh22",   1'b0, 3'b001, 32'h22, 32'h0, 2, 1'b0, 32'h0000_2233);
    xact("lhu23",  1'b0, 3'b101, 32'h23, 32'h0, 3, 1'b0, 32'h0000_1122);

    // 4: halfword load at the last byte wraps to word 0.
    xact("sw_ffc", 1'b1, 3'b010, 32'hFFC, 32'hAB00_0000, 2, 1'b0, 32'h0);
    xact("sw_000", 1'b1, 3'b010, 32'h000, 32'h0000_00CD, 2, 1'b0, 32'h0);
    start(1'b0, 3'b001, 32'hFFF, 32'h0);
    check("wrap_a1_addr", {22'b0, bus.mem_addr}, 32'h3FF);
    check("wrap_a1_we",   {28'b0, bus.mem_we},   32'h0);
    cyc();
    check("wrap_a2_en",   {31'b0, bus.mem_enable}, 32'd1);
    check("wrap_a2_addr", {22'b0, bus.mem_addr},   32'd0);
    cyc();
    check("wrap_rsp",   {31'b0, bus.rsp_valid}, 32'd1);
    check("wrap_rdata", bus.rsp_rdata,          32'hFFFF_CDAB);
    cyc();

    // 5: error paths.
    xact("oor_lw",   1'b0, 3'b010, 32'h1000, 32'h0, 1, 1'b1, 32'h0);
    xact("ld_f3_011", 1'b0, 3'b011, 32'h0,   32'h0, 1, 1'b1, 32'h0);
    xact("ld_f3_110", 1'b0, 3'b110, 32'h0,   32'h0, 1, 1'b1, 32'h0);
    xact("st_f3_011", 1'b1, 3'b011, 32'h0,   32'h0, 1, 1'b1, 32'h0);
    xact("st_f3_100", 1'b1, 3'b100, 32'h0,   32'h0, 1, 1'b1, 32'h0);
    xact("post_err_lw", 1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'h80AD_BEEF);

    // SPLIT_EN=0 instance: word-crossing LH errors, aligned LW goes to memory.
    check("s0_ready", {31'b0, bus0.req_ready}, 32'd1);
    bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_funct3 = 3'b001; bus0.req_addr = 32'h3;
    cyc();
    bus0.req_valid = 1'b0;
    check("s0_lh3_valid", {31'b0, bus0.rsp_valid},  32'd1);
    check("s0_lh3_err",   {31'b0, bus0.rsp_err},    32'd1);
    check("s0_lh3_en",    {31'b0, bus0.mem_enable}, 32'd0);
    cyc();
    check("s0_idle_valid", {31'b0, bus0.rsp_valid}, 32'd0);
    bus0.req_valid = 1'b1; bus0.req_funct3 = 3'b010; bus0.req_addr = 32'h4;
    cyc();
    bus0.req_valid = 1'b0;
    check("s0_lw4_en",   {31'b0, bus0.mem_enable}, 32'd1);
    check("s0_lw4_addr", {22'b0, bus0.mem_addr},   32'd1);
    cyc();
    check("s0_lw4_valid", {31'b0, bus0.rsp_valid}, 32'd1);
    check("s0_lw4_err",   {31'b0, bus0.rsp_err},   32'd0);
    cyc();

    // 6: reset during ACC2 of a split load aborts without a response.
    start(1'b0, 3'b010, 32'h21, 32'h0);
    check("abort_a1_addr", {22'b0, bus.mem_addr}, 32'd8);
    cyc();
    check("abort_a2_addr", {22'b0, bus.mem_addr}, 32'd9);
    rst = 1'b1;
    cyc();
    check("abort_ready", {31'b0, bus.req_ready}, 32'd0);
    check_quiet("abort");
    rst = 1'b0;
    #1;
    check("abort_release_ready", {31'b0, bus.req_ready}, 32'd1);
    saw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      saw |= bus.rsp_valid;
    end
    check("abort_no_rsp", {31'b0, saw}, 32'd0);

    // Held req_valid: one accept per transaction, three aligned loads in nine cycles.
    n_acc = 0;
    n_rsp = 0;
    bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (bus.req_ready) n_acc++;
      if (bus.rsp_valid) begin
        n_rsp++;
        check("hold_rdata", bus.rsp_rdata, 32'h80AD_BEEF);
      end
      cyc();
    end
    bus.req_valid = 1'b0;
    check("hold_accepts",   32'(n_acc), 32'd3);
    check("hold_responses", 32'(n_rsp), 32'd3);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
